// File: rtl/y86_pkg.sv
// Shared y86-64 encodings used by the fetch/decode control slice.
// Also supplies the exception-status predicate used by hazard and halt logic.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] IRRMOVQ = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam logic [3:0] SAOK = 4'd1;
  localparam logic [3:0] SHLT = 4'd2;
  localparam logic [3:0] SADR = 4'd3;
  localparam logic [3:0] SINS = 4'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // Statuses that stop the machine; AOK and unknown encodings do not.
  function automatic logic is_exc_stat(input logic [3:0] stat);
    return (stat == SADR) || (stat == SINS) || (stat == SHLT);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// Combinational pipeline control: load-use, return, mispredict and exception handling.
module pipe_hazard_unit
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [3:0] m_Stat,
  input  logic [3:0] W_Stat,
  input  logic       halted,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall
);

  logic load_use;
  logic ret_in_flight;
  logic mispred;

  // RNONE guard keeps a no-destination load from matching an unused source slot.
  assign load_use = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) &&
                    (E_dstM != RNONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  assign ret_in_flight = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign mispred       = (E_icode == IJXX) && !e_Cnd;

  assign F_stall  = load_use || ret_in_flight || halted;
  assign D_stall  = load_use || halted;
  assign D_bubble = !D_stall && (mispred || ret_in_flight);
  assign E_bubble = mispred || load_use;
  assign M_bubble = is_exc_stat(m_Stat) || is_exc_stat(W_Stat);
  assign W_stall  = is_exc_stat(W_Stat);

endmodule

// File: rtl/fetch_feed_ctrl.sv
// Fetch-side pipeline control: F register, D register, sticky halt and hazard control.
// Optional saturating performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_feed_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      f_predPC,
  input  logic [3:0]       f_icode,
  input  logic [3:0]       f_ifun,
  input  logic [3:0]       f_rA,
  input  logic [3:0]       f_rB,
  input  logic [63:0]      f_valC,
  input  logic [63:0]      f_valP,
  input  logic [3:0]       f_Stat,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_Stat,
  input  logic [3:0]       W_Stat,
  output logic [63:0]      F_predPC,
  output logic [3:0]       D_icode,
  output logic [3:0]       D_ifun,
  output logic [3:0]       D_rA,
  output logic [3:0]       D_rB,
  output logic [63:0]      D_valC,
  output logic [63:0]      D_valP,
  output logic [3:0]       D_Stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
`ifdef FETCH_PERF_CNT_EN
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_fstall,
  output logic [CNT_W-1:0] perf_dbubble,
`endif
  output logic             halted
);

  pipe_hazard_unit u_hazard (
    .D_icode  (D_icode),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .E_icode  (E_icode),
    .E_dstM   (E_dstM),
    .e_Cnd    (e_Cnd),
    .M_icode  (M_icode),
    .m_Stat   (m_Stat),
    .W_Stat   (W_Stat),
    .halted   (halted),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .D_bubble (D_bubble),
    .E_bubble (E_bubble),
    .M_bubble (M_bubble),
    .W_stall  (W_stall)
  );

  // F stage: predicted PC presented to fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      F_predPC <= RESET_PC;
    end else if (!F_stall) begin
      F_predPC <= f_predPC;
    end
  end

  // D stage: stall holds, bubble injects a NOP, otherwise capture fetch outputs
  always_ff @(posedge clk) begin
    if (rst || (!D_stall && D_bubble)) begin
      D_icode <= INOP;
      D_ifun  <= 4'd0;
      D_rA    <= RNONE;
      D_rB    <= RNONE;
      D_valC  <= 64'd0;
      D_valP  <= 64'd0;
      D_Stat  <= SAOK;
    end else if (!D_stall) begin
      D_icode <= f_icode;
      D_ifun  <= f_ifun;
      D_rA    <= f_rA;
      D_rB    <= f_rB;
      D_valC  <= f_valC;
      D_valP  <= f_valP;
      D_Stat  <= f_Stat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (is_exc_stat(W_Stat)) begin
      halted <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles  <= '0;
      perf_fstall  <= '0;
      perf_dbubble <= '0;
    end else begin
      if (!halted)  perf_cycles  <= sat_inc(perf_cycles);
      if (F_stall)  perf_fstall  <= sat_inc(perf_fstall);
      if (D_bubble) perf_dbubble <= sat_inc(perf_dbubble);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_feed_ctrl.sv
// Self-checking bench for fetch_feed_ctrl with a scoreboard of expected F/D register contents.
module tb_fetch_feed_ctrl;
  import y86_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          CNT_W    = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] f_predPC, f_valC, f_valP;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB, f_Stat;
  logic [3:0]  d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_Stat, W_Stat;
  logic        e_Cnd;
  logic [63:0] F_predPC, D_valC, D_valP;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_Stat;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] perf_cycles, perf_fstall, perf_dbubble;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] valP;
    logic [3:0]  icode;
  } exp_t;
  exp_t sb[$];

  fetch_feed_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .f_predPC(f_predPC), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .f_Stat(f_Stat),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_Stat(m_Stat), .W_Stat(W_Stat),
    .F_predPC(F_predPC), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_Stat(D_Stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall),
`ifdef FETCH_PERF_CNT_EN
    .perf_cycles(perf_cycles), .perf_fstall(perf_fstall), .perf_dbubble(perf_dbubble),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_predPC = 64'h0; f_icode = IOPQ; f_ifun = 4'd0; f_rA = 4'd1; f_rB = 4'd2;
    f_valC = 64'h0; f_valP = 64'h0; f_Stat = SAOK;
    d_srcA = RNONE; d_srcB = RNONE; E_icode = INOP; E_dstM = RNONE; e_Cnd = 1'b1;
    M_icode = INOP; m_Stat = SAOK; W_Stat = SAOK;
  endtask

  // Packs the six control outputs as {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall}.
  function automatic logic [5:0] ctl();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
  endfunction

  task automatic check_ctl(input string name, input logic [5:0] exp);
    checks++;
    if (ctl() !== exp) begin
      errors++;
      $display("FAIL %s: ctl got %b expected %b", name, ctl(), exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    f_predPC = 64'hDEAD; f_valP = 64'hBEEF; f_icode = IRET;
    rst = 1'b1;
    step();
    rst = 1'b0;
    f_icode = IOPQ;
    checks++; if (F_predPC !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", F_predPC, RESET_PC); end
    checks++; if (D_icode !== INOP) begin errors++; $display("FAIL reset_icode: got %0d expected 1", D_icode); end
    checks++; if (D_rA !== RNONE || D_rB !== RNONE) begin errors++; $display("FAIL reset_regs: got %h/%h expected f/f", D_rA, D_rB); end
    checks++; if (D_Stat !== SAOK) begin errors++; $display("FAIL reset_stat: got %0d expected 1", D_Stat); end
    checks++; if (D_valP !== 64'd0 || D_valC !== 64'd0) begin errors++; $display("FAIL reset_vals: got %h/%h expected 0/0", D_valC, D_valP); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_cycles !== '0) begin errors++; $display("FAIL reset_perf: got %0d expected 0", perf_cycles); end
`endif
  endtask

  task automatic test_follow();
    exp_t e;
    for (int i = 1; i <= 3; i++) begin
      f_predPC = 64'(i * 10);
      f_valP   = 64'(i * 10 + 2);
      f_icode  = (i == 2) ? IIRMOVQ : IOPQ;
      #1;
      check_ctl("follow_ctl", 6'b000000);
      sb.push_back('{pc: f_predPC, valP: f_valP, icode: f_icode});
      step();
      e = sb.pop_front();
      checks++; if (F_predPC !== e.pc) begin errors++; $display("FAIL follow_pc: got %0d expected %0d", F_predPC, e.pc); end
      checks++; if (D_valP !== e.valP || D_icode !== e.icode) begin errors++; $display("FAIL follow_d: got %0d/%0d expected %0d/%0d", D_valP, D_icode, e.valP, e.icode); end
    end
  endtask

  task automatic test_load_use();
    E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
    f_predPC = 64'd99; f_valP = 64'd77;
    #1;
    check_ctl("load_use_ctl", 6'b110100);
    step();
    checks++; if (F_predPC !== 64'd30) begin errors++; $display("FAIL load_use_pc: got %0d expected 30", F_predPC); end
    checks++; if (D_valP !== 64'd32) begin errors++; $display("FAIL load_use_d: got %0d expected 32", D_valP); end
    // Load with no destination must not stall even against RNONE sources.
    E_icode = IPOPQ; E_dstM = RNONE; d_srcA = RNONE; d_srcB = RNONE;
    #1;
    check_ctl("load_rnone_ctl", 6'b000000);
    E_icode = IPOPQ; E_dstM = 4'd6; d_srcB = 4'd6;
    #1;
    check_ctl("load_use_srcB_ctl", 6'b110100);
    idle_inputs();
  endtask

  task automatic test_mispred();
    E_icode = IJXX; e_Cnd = 1'b0; f_predPC = 64'd40; f_valP = 64'd41;
    #1;
    check_ctl("mispred_ctl", 6'b001100);
    step();
    checks++; if (F_predPC !== 64'd40) begin errors++; $display("FAIL mispred_pc: got %0d expected 40", F_predPC); end
    checks++; if (D_icode !== INOP || D_valP !== 64'd0) begin errors++; $display("FAIL mispred_d: got %0d/%0d expected 1/0", D_icode, D_valP); end
    e_Cnd = 1'b1;
    #1;
    check_ctl("taken_ctl", 6'b000000);
    idle_inputs();
  endtask

  task automatic test_ret();
    exp_t e;
    f_icode = IRET; f_predPC = 64'd50; f_valP = 64'd51;
    sb.push_back('{pc: 64'd50, valP: 64'd51, icode: IRET});
    step();
    e = sb.pop_front();
    checks++; if (D_icode !== e.icode || F_predPC !== e.pc) begin errors++; $display("FAIL ret_load: got %0d/%0d expected %0d/%0d", D_icode, F_predPC, e.icode, e.pc); end
    f_icode = IOPQ; f_predPC = 64'd60;
    for (int c = 0; c < 3; c++) begin
      E_icode = (c == 1) ? IRET : INOP;
      M_icode = (c == 2) ? IRET : INOP;
      #1;
      check_ctl("ret_ctl", 6'b101000);
      step();
      checks++; if (F_predPC !== 64'd50) begin errors++; $display("FAIL ret_pc: got %0d expected 50", F_predPC); end
    end
    M_icode = IRET; E_icode = IJXX; e_Cnd = 1'b0;
    #1;
    check_ctl("ret_mispred_ctl", 6'b101100);
    E_icode = IMRMOVQ; E_dstM = 4'd2; d_srcA = 4'd2;
    #1;
    check_ctl("ret_load_use_ctl", 6'b110100);
    idle_inputs();
    #1;
    check_ctl("ret_clear_ctl", 6'b000000);
  endtask

  task automatic test_halt();
    logic [63:0] pc_hold;
    logic [3:0]  ic_hold;
`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_hold;
`endif
    m_Stat = SHLT;
    #1;
    check_ctl("m_exc_ctl", 6'b000010);
    m_Stat = SAOK; W_Stat = SADR; f_predPC = 64'd70;
    #1;
    check_ctl("w_exc_ctl", 6'b000011);
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halted); end
    pc_hold = F_predPC; ic_hold = D_icode;
    checks++; if (pc_hold !== 64'd70) begin errors++; $display("FAIL halt_edge_pc: got %0d expected 70", pc_hold); end
    W_Stat = SAOK; f_predPC = 64'd123; f_icode = IIRMOVQ;
    #1;
    check_ctl("halt_ctl", 6'b110000);
`ifdef FETCH_PERF_CNT_EN
    cyc_hold = perf_cycles;
`endif
    step(); step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", halted); end
    checks++; if (F_predPC !== 64'd70 || D_icode !== ic_hold) begin errors++; $display("FAIL halt_freeze: got %0d/%0d expected 70/%0d", F_predPC, D_icode, ic_hold); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_cycles !== cyc_hold) begin errors++; $display("FAIL halt_perf: got %0d expected %0d", perf_cycles, cyc_hold); end
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (halted !== 1'b0 || F_predPC !== RESET_PC) begin errors++; $display("FAIL halt_clear: got %b/%h expected 0/%h", halted, F_predPC, RESET_PC); end
    step();
    checks++; if (F_predPC !== 64'd123) begin errors++; $display("FAIL resume_pc: got %0d expected 123", F_predPC); end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_follow();
    test_load_use();
    test_mispred();
    test_ret();
    test_halt();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
